// File: rtl/mod_inputs_pkg.sv
// Shared definitions for the memory-mapped input peripheral:
// register word offsets and input counts.
package mod_inputs_pkg;

  typedef enum logic [1:0] {
    INPUTS_SW    = 2'd0,
    INPUTS_BTN   = 2'd1,
    INPUTS_PRESS = 2'd2,
    INPUTS_MASK  = 2'd3
  } reg_off_e;

  localparam int N_SW  = 8;
  localparam int N_BTN = 4;
  localparam int N_IN  = N_SW + N_BTN;

endpackage

// File: rtl/mod_debounce.sv
// Single-bit two-flop synchronizer plus stability counter.
// Ports: clk, rst (sync, active-high), raw_i (async pin),
//        db_o (debounced level), rise_o (db_o about to go 0->1).
module mod_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], raw_i};
    db_d   = db_q;
    cnt_d  = cnt_q;
    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulses in the cycle whose edge commits a 0->1 change,
  // so the press latch sets on the same edge as db_o.
  assign rise_o = db_d & ~db_q;
  assign db_o   = db_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_inputs.sv
// Memory-mapped switch/button input peripheral with press latch and irq.
// Ports: clk, rst, bus (de, daddr, drw, din, dout), switches, buttons, irq.
module mod_inputs
  import mod_inputs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic [31:0] daddr,
  input  logic        drw,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [7:0]  switches,
  input  logic [3:0]  buttons,
  output logic        irq
);

  logic [N_IN-1:0] raw, db, rise;
  logic [N_SW-1:0] d_sw;
  logic [N_BTN-1:0] d_btn, btn_rise;

  assign raw = {buttons, switches};

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    mod_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[i]),
      .db_o  (db[i]),
      .rise_o(rise[i])
    );
  end

  assign d_sw     = db[N_SW-1:0];
  assign d_btn    = db[N_IN-1:N_SW];
  assign btn_rise = rise[N_IN-1:N_SW];

  reg_off_e off;
  logic     wr;
  assign off = reg_off_e'(daddr[3:2]);
  assign wr  = de & drw;

  logic [3:0] press_q, press_d;
  logic [3:0] mask_q, mask_d;
  logic       irq_q, irq_d;
  logic [3:0] clr;

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    if (wr && off == INPUTS_PRESS) clr = din[3:0];
    if (wr && off == INPUTS_MASK) mask_d = din[3:0];
    // OR-ing the set term last lets a new press beat a W1C.
    press_d = (press_q & ~clr) | btn_rise;
    irq_d   = |(press_q & mask_q);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      press_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    dout = 32'h0;
    if (de) begin
      unique case (off)
        INPUTS_SW:    dout = {24'h0, d_sw};
        INPUTS_BTN:   dout = {28'h0, d_btn};
        INPUTS_PRESS: dout = {28'h0, press_q};
        INPUTS_MASK:  dout = {28'h0, mask_q};
        default:      dout = 32'h0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{daddr[31:4], daddr[1:0], din[31:4]};

endmodule

// File: tb/tb_mod_inputs.sv
// Directed self-checking bench for mod_inputs.
// Small debounce window (4 cycles) keeps the sequences short.
module tb_mod_inputs;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic [31:0] daddr;
  logic        drw;
  logic [31:0] din;
  logic [31:0] dout;
  logic [7:0]  switches;
  logic [3:0]  buttons;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_inputs #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .de      (de),
    .daddr   (daddr),
    .drw     (drw),
    .din     (din),
    .dout    (dout),
    .switches(switches),
    .buttons (buttons),
    .irq     (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one active (falling) edge; return on the rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] off,
                    input logic [31:0] exp);
    de    = 1'b1;
    drw   = 1'b0;
    daddr = {28'h0, off, 2'b00};
    #1;
    chk(tag, dout, exp);
    de = 1'b0;
  endtask

  task automatic set_wr(input logic [1:0] off,
                        input logic [31:0] data);
    de    = 1'b1;
    drw   = 1'b1;
    daddr = {28'h0, off, 2'b00};
    din   = data;
  endtask

  task automatic end_wr;
    de  = 1'b0;
    drw = 1'b0;
    din = 32'h0;
  endtask

  task automatic wr(input logic [1:0] off,
                    input logic [31:0] data);
    set_wr(off, data);
    tick(1);
    end_wr();
  endtask

  initial begin
    rst      = 1'b1;
    de       = 1'b0;
    daddr    = 32'h0;
    drw      = 1'b0;
    din      = 32'h0;
    switches = 8'h0;
    buttons  = 4'h0;
    @(posedge clk);
    tick(2);
    rst = 1'b0;

    rd("rst_sw", 2'd0, 32'h0);
    rd("rst_btn", 2'd1, 32'h0);
    rd("rst_press", 2'd2, 32'h0);
    rd("rst_mask", 2'd3, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // Switch latency: 2 sync + 4 stable edges.
    switches = 8'hA5;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      rd($sformatf("sw_early_%0d", k), 2'd0, 32'h0);
    end
    tick(1);
    rd("sw_n6", 2'd0, 32'h0000_00A5);
    tick(1);
    rd("sw_n7", 2'd0, 32'h0000_00A5);
    daddr = 32'h0;
    #1;
    chk("de0_dout", dout, 32'h0);

    // 3-cycle glitch must be rejected.
    buttons = 4'h2;
    tick(3);
    buttons = 4'h0;
    tick(8);
    rd("glitch_btn", 2'd1, 32'h0);
    rd("glitch_press", 2'd2, 32'h0);

    // 4-cycle pulse is accepted.
    buttons = 4'h2;
    tick(4);
    buttons = 4'h0;
    tick(1);
    rd("pulse_btn_n5", 2'd1, 32'h0);
    tick(1);
    rd("pulse_btn", 2'd1, 32'h2);
    rd("pulse_press", 2'd2, 32'h2);
    chk("pulse_irq_unmasked", {31'h0, irq}, 32'h0);
    tick(8);
    rd("release_btn", 2'd1, 32'h0);
    rd("release_press", 2'd2, 32'h2);

    // Clear, then mask button 1 and press it.
    wr(2'd2, 32'h2);
    rd("w1c_press", 2'd2, 32'h0);
    wr(2'd3, 32'h2);
    rd("mask_rd", 2'd3, 32'h2);
    buttons = 4'h2;
    tick(6);
    rd("irq_press", 2'd2, 32'h2);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h2);
    rd("irq_clr_press", 2'd2, 32'h0);
    chk("irq_clr_lag", {31'h0, irq}, 32'h1);
    tick(1);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    buttons = 4'h0;
    tick(8);

    // Rising edge of button 0 coincides with a W1C of bit 0.
    buttons = 4'h1;
    tick(5);
    rd("setwin_pre", 2'd2, 32'h0);
    set_wr(2'd2, 32'h1);
    tick(1);
    end_wr();
    rd("setwin_press", 2'd2, 32'h1);
    rd("setwin_btn", 2'd1, 32'h1);
    buttons = 4'h0;
    tick(8);
    wr(2'd2, 32'h1);
    rd("setwin_clr", 2'd2, 32'h0);

    // Reset while button 2's count is at 3.
    buttons = 4'h4;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rd("rst_mid_btn", 2'd1, 32'h0);
    rd("rst_mid_mask", 2'd3, 32'h0);
    rd("rst_mid_sw", 2'd0, 32'h0);
    tick(5);
    rd("rst_btn_n5", 2'd1, 32'h0);
    tick(1);
    rd("rst_btn_n6", 2'd1, 32'h4);
    rd("rst_press_n6", 2'd2, 32'h4);
    chk("rst_irq_masked", {31'h0, irq}, 32'h0);

    // Read-only offsets ignore writes.
    wr(2'd0, 32'h0);
    rd("ro_sw", 2'd0, 32'h0000_00A5);
    wr(2'd1, 32'h0);
    rd("ro_btn", 2'd1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
